// File: rtl/apx_mult_arbiter.sv
// apx_mult_arbiter: round-robin scheduler that shares one approximate/accurate
// multiplier pair among NREQ requesters and returns the selected product with the
// requester's ID.
// Latency: resp_valid rises MUL_LAT cycles after the accept edge. One operation
// is in flight at a time, so the minimum issue interval is MUL_LAT+2 cycles.
// Backpressure: the response is held in RESP until resp_ready. req_ready stays 0
// outside IDLE, and requesters are expected to hold req_valid until accepted.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b                  packed operands, requester i at [i*W +: W]
//   req_acc                      per-requester result select (1 = accurate)
//   mult_a/mult_b                registered operands to the shared multipliers
//   mult_c_apx/mult_c_acc        multiplier results (low W bits)
//   resp_valid/resp_ready        response handshake
//   resp_data/resp_id/resp_acc   product, owner index, echoed select
//   busy                         high whenever the block is not idle
module apx_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int W       = 32,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_acc,
  output logic [W-1:0]      mult_a,
  output logic [W-1:0]      mult_b,
  input  logic [W-1:0]      mult_c_apx,
  input  logic [W-1:0]      mult_c_acc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_acc,
  output logic              busy
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic           acc_q, acc_d;
  logic [CW-1:0]  lat_cnt_q, lat_cnt_d;
  logic [W-1:0]   mult_a_q, mult_a_d;
  logic [W-1:0]   mult_b_q, mult_b_d;
  logic [W-1:0]   resp_data_q, resp_data_d;

  logic            gnt_vld;
  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_idx;
  logic [W-1:0]    sel_a, sel_b;
  logic            sel_acc;

  // Round-robin pick: first pass looks at indices >= rr_ptr, second pass wraps
  // around to the lowest requester. The operand mux then follows the one-hot grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_acc = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && req_valid[i] && (i >= int'(rr_ptr_q))) begin
        gnt_vld   = 1'b1;
        gnt_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && req_valid[i]) begin
        gnt_vld   = 1'b1;
        gnt_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        gnt_idx = IDW'(i);
        sel_a   = req_a[i*W +: W];
        sel_b   = req_b[i*W +: W];
        sel_acc = req_acc[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    acc_d       = acc_q;
    lat_cnt_d   = lat_cnt_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    resp_data_d = resp_data_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req_ready = gnt_oh;
          mult_a_d  = sel_a;
          mult_b_d  = sel_b;
          acc_d     = sel_acc;
          id_d      = gnt_idx;
          lat_cnt_d = CW'(MUL_LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - CW'(1);
        if (lat_cnt_q == CW'(1)) begin
          resp_data_d = acc_q ? mult_c_acc : mult_c_apx;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rr_ptr_d = IDW'((int'(id_q) + 1) % NREQ);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The state register sits in IDLE while reset is held, so the grant must be
    // masked explicitly to keep req_ready low during reset.
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      acc_q       <= 1'b0;
      lat_cnt_q   <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      acc_q       <= acc_d;
      lat_cnt_q   <= lat_cnt_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_id    = id_q;
  assign resp_acc   = acc_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_apx_mult_arbiter.sv
module tb_apx_mult_arbiter;

  localparam int LAT1 = 1;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with MUL_LAT=1
  logic         rst;
  logic [3:0]   req_valid, req_ready, req_acc;
  logic [127:0] req_a, req_b;
  logic [31:0]  mult_a, mult_b, c_apx, c_acc, resp_data;
  logic         resp_valid, resp_ready, resp_acc, busy;
  logic [1:0]   resp_id;

  // Instance with MUL_LAT=3
  logic         rst3;
  logic [3:0]   req_valid3, req_ready3, req_acc3;
  logic [127:0] req_a3, req_b3;
  logic [31:0]  mult_a3, mult_b3, c_apx3, c_acc3, resp_data3;
  logic         resp_valid3, resp_ready3, resp_acc3, busy3;
  logic [1:0]   resp_id3;

  // Multiplier stand-ins: accurate is the true low product, approximate clears the low byte.
  assign c_acc  = mult_a * mult_b;
  assign c_apx  = c_acc & 32'hFFFF_FF00;
  assign c_acc3 = mult_a3 * mult_b3;
  assign c_apx3 = c_acc3 & 32'hFFFF_FF00;

  apx_mult_arbiter #(.NREQ(4), .IDW(2), .W(32), .MUL_LAT(LAT1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
    .mult_a(mult_a), .mult_b(mult_b), .mult_c_apx(c_apx), .mult_c_acc(c_acc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_acc(resp_acc), .busy(busy)
  );

  apx_mult_arbiter #(.NREQ(4), .IDW(2), .W(32), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_acc(req_acc3),
    .mult_a(mult_a3), .mult_b(mult_b3), .mult_c_apx(c_apx3), .mult_c_acc(c_acc3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3),
    .resp_id(resp_id3), .resp_acc(resp_acc3), .busy(busy3)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level reference state
  logic [3:0]  pend;
  logic [31:0] pa [4];
  logic [31:0] pb [4];
  logic        pacc [4];
  logic        inflight;
  int          age, ptr, eid, cyc;
  logic [31:0] ea, eb, edata;
  logic        eacc;
  int          gnt_log [$];
  int          cyc_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b, input logic acc);
    logic [31:0] p;
    p = a * b;
    return acc ? p : (p & 32'hFFFF_FF00);
  endfunction

  task automatic model_reset();
    pend = '0; inflight = 1'b0; ptr = 0; age = 0;
  endtask

  task automatic reset1();
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Single directed operation on the MUL_LAT=1 instance, resp_ready held high.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic acc, input logic [31:0] exp_data);
    logic [3:0] oh;
    oh = 4'(1 << id);
    @(negedge clk);
    req_valid = oh; req_a[id*32 +: 32] = a; req_b[id*32 +: 32] = b; req_acc = acc ? oh : 4'b0;
    resp_ready = 1'b1;
    #1 chk("op_grant", req_ready, oh);
    @(negedge clk);
    req_valid = '0;
    #1 chk("op_wait_valid", resp_valid, 0);
    chk("op_wait_busy", busy, 1);
    chk("op_mult_a", mult_a, a);
    chk("op_mult_b", mult_b, b);
    @(negedge clk);
    #1 chk("op_resp_valid", resp_valid, 1);
    chk("op_resp_data", resp_data, exp_data);
    chk("op_resp_id", resp_id, id);
    chk("op_resp_acc", resp_acc, acc);
    @(negedge clk);
    #1 chk("op_done_valid", resp_valid, 0);
    chk("op_done_busy", busy, 0);
  endtask

  // Randomised traffic checked cycle by cycle against the transaction model.
  task automatic run_cycles(input int n, input int req_pct, input int rdy_pct);
    int pick;
    logic exp_rv;
    logic [3:0] exp_rdy;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(99) < req_pct)) begin
          pend[i] = 1'b1; pa[i] = $urandom; pb[i] = $urandom; pacc[i] = 1'($urandom_range(1));
        end
        req_a[i*32 +: 32] = pa[i];
        req_b[i*32 +: 32] = pb[i];
        req_acc[i] = pacc[i];
      end
      req_valid  = pend;
      resp_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (inflight) age++;
      exp_rv  = inflight && (age >= LAT1 + 1);
      pick    = inflight ? -1 : rr_pick(ptr, pend);
      exp_rdy = (pick >= 0) ? 4'(1 << pick) : 4'b0;
      chk("rnd_req_ready", req_ready, exp_rdy);
      chk("rnd_busy", busy, inflight);
      chk("rnd_resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
        chk("rnd_resp_data", resp_data, edata);
        chk("rnd_resp_id", resp_id, eid);
        chk("rnd_resp_acc", resp_acc, eacc);
      end
      if (inflight) begin
        chk("rnd_mult_a", mult_a, ea);
        chk("rnd_mult_b", mult_b, eb);
      end
      if (exp_rv && resp_ready) begin
        inflight = 1'b0;
        ptr = (eid + 1) % 4;
      end else if (pick >= 0) begin
        inflight = 1'b1; age = 0; eid = pick;
        ea = pa[pick]; eb = pb[pick]; eacc = pacc[pick];
        edata = prod(ea, eb, eacc);
        pend[pick] = 1'b0;
        gnt_log.push_back(pick);
        cyc_log.push_back(cyc);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0; req_acc = '0; resp_ready = 1'b0;
    rst3 = 1'b1; req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_acc3 = '0; resp_ready3 = 1'b0;
    for (int i = 0; i < 4; i++) begin pa[i] = '0; pb[i] = '0; pacc[i] = 1'b0; end
    model_reset();
    cyc = 0; eid = 0; ea = '0; eb = '0; eacc = 1'b0; edata = '0;

    // Reset with all requests pending
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_acc", resp_acc, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1 chk("rst_release_grant", req_ready, 4'b0001);
    @(negedge clk);
    #1 chk("first_accept_busy", busy, 1);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    #1 chk("midop_rst_busy", busy, 0);
    chk("midop_rst_valid", resp_valid, 0);
    rst = 1'b0;

    // Directed single operations: accurate, then approximate
    do_op(2, 32'h0000_1234, 32'h0000_0010, 1'b1, 32'h0001_2340);
    do_op(2, 32'h0000_1234, 32'h0000_0010, 1'b0, 32'h0001_2300);

    // Round robin with every requester continuously valid
    reset1();
    gnt_log.delete(); cyc_log.delete();
    run_cycles(16, 100, 100);
    chk("rr_count", gnt_log.size() >= 5, 1);
    if (gnt_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("rr_id", gnt_log[k], k % 4);
      for (int k = 1; k < 5; k++) chk("rr_spacing", cyc_log[k] - cyc_log[k-1], LAT1 + 2);
    end

    // Backpressure, then random traffic
    run_cycles(10, 100, 0);
    run_cycles(300, 40, 60);

    // MUL_LAT=3: exact latency, then reset in the second WAIT cycle
    @(negedge clk);
    rst3 = 1'b0; req_valid3 = 4'b0010; req_a3[32 +: 32] = 32'd7; req_b3[32 +: 32] = 32'd9;
    req_acc3 = 4'b0010; resp_ready3 = 1'b1;
    #1 chk("l3_grant", req_ready3, 4'b0010);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_valid3 = '0;
      #1 chk("l3_wait_valid", resp_valid3, 0);
    end
    @(negedge clk);
    #1 chk("l3_rise", resp_valid3, 1);
    chk("l3_data", resp_data3, 32'd63);
    chk("l3_id", resp_id3, 1);
    chk("l3_acc", resp_acc3, 1);
    @(negedge clk);
    req_valid3 = 4'b0001; req_a3[31:0] = 32'd11; req_b3[31:0] = 32'd13; req_acc3 = 4'b0000;
    #1 chk("l3_grant2", req_ready3, 4'b0001);
    @(negedge clk);
    req_valid3 = '0;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    #1 chk("l3_rst_busy", busy3, 0);
    chk("l3_rst_valid", resp_valid3, 0);
    chk("l3_rst_mult_a", mult_a3, 0);
    rst3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 chk("l3_no_resp", resp_valid3, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
